mmu_m: RTL and testbench

Memory management unit that consumes the CPU's `mem_if` requests and routes them to cartridge ROM, internal work RAM (WRAM) and high RAM (HRAM), the interrupt registers, and an external port serving VRAM, OAM and other I/O. It owns the IF/IE registers, which feed `mmio_reg_IF` and `mmio_reg_IE` back into the CPU. It also contains the OAM DMA engine (FF46).

---
 rtl/mmu_m_pkg.sv | 53 +++++
 rtl/mmu_m_if.sv | 13 +
 rtl/mmu_m_oam_dma.sv | 102 ++++++++++
 rtl/mmu_m.sv | 152 +++++++++++++++
 tb/tb_mmu_m.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_m_pkg.sv
// rtl/mmu_m_pkg.sv - shared memory-map types, constants and address decode
// Purpose: region and DMA state enums, fixed register addresses, and the
//          address decoders used by the MMU and its OAM DMA engine.
// Ports:   none (package).
package cpu_defs;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_WRAM,
        REG_HRAM,
        REG_IF,
        REG_IE,
        REG_DMA,
        REG_EXT,
        REG_NONE
    } mem_region_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    localparam logic [15:0] ADDR_IF  = 16'hFF0F;
    localparam logic [15:0] ADDR_IE  = 16'hFFFF;
    localparam logic [15:0] ADDR_DMA = 16'hFF46;
    localparam logic [15:0] OAM_BASE = 16'hFE00;

    // CPU view of the map. Order matters: FFFF must match IE before the
    // FF80+ HRAM test.
    function automatic mem_region_t decode_addr(input logic [15:0] addr);
        mem_region_t r;
        if (addr <= 16'h7FFF)                         r = REG_ROM;
        else if (addr >= 16'hC000 && addr <= 16'hFDFF) r = REG_WRAM;
        else if (addr >= 16'hFEA0 && addr <= 16'hFEFF) r = REG_NONE;
        else if (addr == ADDR_IF)                      r = REG_IF;
        else if (addr == ADDR_DMA)                     r = REG_DMA;
        else if (addr == ADDR_IE)                      r = REG_IE;
        else if (addr >= 16'hFF80)                     r = REG_HRAM;
        else                                           r = REG_EXT;
        return r;
    endfunction

    // DMA source view: pages FE and FF are not readable by the engine and
    // copy as FF.
    function automatic mem_region_t dma_src_region(input logic [15:0] addr);
        mem_region_t r;
        if (addr >= 16'hFE00) r = REG_NONE;
        else                  r = decode_addr(addr);
        return r;
    endfunction

endpackage

// File: rtl/mmu_m_if.sv
// rtl/mmu_m_if.sv - CPU memory request interface
// Purpose: groups the CPU-side address/write/read signals of the MMU.
// Ports:   addr_select[15:0], write_value[7:0], write_enable (master->slave),
//          read_out[7:0] (slave->master).
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (output addr_select, output write_value, output write_enable, input read_out);
    modport slave  (input addr_select, input write_value, input write_enable, output read_out);
endinterface

// File: rtl/mmu_m_oam_dma.sv
// rtl/mmu_m_oam_dma.sv - OAM DMA engine (FF46)
// Purpose: copies LEN bytes from {page,00} to OAM, CLKS_PER_BYTE clocks per
//          byte: first half reads the source, second half writes OAM.
// Ports:   clk, rst; start/src_page (restart request); rdata (source data,
//          1-clock latency); active; src_addr; oam_phase; oam_we/oam_addr/
//          oam_wdata (one-clock OAM write strobe per byte).
module oam_dma_m
    import cpu_defs::*;
#(
    parameter int CLKS_PER_BYTE = 4,
    parameter int LEN           = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  src_page,
    input  logic [7:0]  rdata,
    output logic        active,
    output logic [15:0] src_addr,
    output logic        oam_phase,
    output logic        oam_we,
    output logic [15:0] oam_addr,
    output logic [7:0]  oam_wdata
);

    localparam int CW   = (CLKS_PER_BYTE > 2) ? $clog2(CLKS_PER_BYTE) : 1;
    localparam int HALF = CLKS_PER_BYTE / 2;
    localparam logic [CW-1:0] RD_LAST   = CW'(HALF - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(CLKS_PER_BYTE - 1);
    localparam logic [7:0]    IDX_LAST  = 8'(LEN - 1);

    dma_state_t    state_q, state_d;
    logic [15:0]   src_q, src_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            src_q   <= 16'h0000;
            idx_q   <= 8'h00;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        if (start) begin
            // A new FF46 write always restarts, even mid-transfer.
            state_d = DMA_READ;
            src_d   = {src_page, 8'h00};
            idx_d   = 8'h00;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DMA_READ: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == RD_LAST) begin
                        // Source data issued on the first read clock is valid now.
                        byte_d  = rdata;
                        state_d = DMA_WRITE;
                    end
                end
                DMA_WRITE: begin
                    if (cnt_q == BYTE_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = DMA_IDLE;
                            idx_d   = 8'h00;
                        end else begin
                            state_d = DMA_READ;
                            idx_d   = idx_q + 8'h01;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign active    = (state_q != DMA_IDLE);
    assign src_addr  = src_q + {8'h00, idx_q};
    assign oam_phase = (state_q == DMA_WRITE);
    assign oam_we    = oam_phase && (cnt_q == BYTE_LAST);
    assign oam_addr  = OAM_BASE + {8'h00, idx_q};
    assign oam_wdata = byte_q;

endmodule

// File: rtl/mmu_m.sv
// rtl/mmu_m.sv - memory management unit: decode, WRAM/HRAM, IF/IE, OAM DMA
// Purpose: routes CPU requests to ROM, WRAM (+echo), HRAM, IF/IE, FF46 and
//          the external port; hosts the OAM DMA engine which locks the bus.
// Ports:   clk, rst (async, active high); bus (mem_if.slave, CPU side);
//          rom_addr/rom_data; ext_addr/ext_wdata/ext_we/ext_rdata;
//          irq_req[4:0]; mmio_reg_IF, mmio_reg_IE; dma_active.
module mmu_m
    import cpu_defs::*;
#(
    parameter int DMA_CLKS_PER_BYTE = 4,
    parameter int DMA_LEN           = 160
) (
    input  logic        clk,
    input  logic        rst,
    mem_if.slave        bus,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    input  logic [7:0]  ext_rdata,
    input  logic [4:0]  irq_req,
    output logic [7:0]  mmio_reg_IF,
    output logic [7:0]  mmio_reg_IE,
    output logic        dma_active
);

    mem_region_t cpu_reg, cpu_reg_q, dma_reg_q;
    logic        cpu_priv, cpu_we, wr_dma_q, dma_start, rd_primed_q;
    logic [4:0]  if_q;
    logic [7:0]  ie_q, dma_latch_q, wram_q, hram_q, dma_rdata, read_mux;
    logic [12:0] wram_rd_idx;
    logic [6:0]  hram_idx;
    logic [15:0] dma_src, dma_oam_addr;
    logic        dma_oam_phase, dma_oam_we;
    logic [7:0]  dma_oam_wdata;

    logic [7:0] wram [0:8191];
    logic [7:0] hram [0:126];

    assign cpu_reg  = decode_addr(bus.addr_select);
    // These stay reachable while DMA owns the rest of the bus.
    assign cpu_priv = (cpu_reg == REG_HRAM) || (cpu_reg == REG_IF) ||
                      (cpu_reg == REG_IE)   || (cpu_reg == REG_DMA);
    assign cpu_we   = bus.write_enable && (!dma_active || cpu_priv);

    // The CPU holds write_enable for several clocks; only the first clock of
    // an FF46 write starts DMA so a held write does not keep restarting it.
    assign dma_start = cpu_we && (cpu_reg == REG_DMA) && !wr_dma_q;

    // Echo E000-FDFF minus 2000 lands on the same low 13 bits as C000-DFFF.
    assign wram_rd_idx = dma_active ? dma_src[12:0] : bus.addr_select[12:0];
    assign hram_idx    = bus.addr_select[6:0];

    always_ff @(posedge clk) begin
        if (cpu_we && cpu_reg == REG_WRAM) wram[bus.addr_select[12:0]] <= bus.write_value;
        if (cpu_we && cpu_reg == REG_HRAM) hram[hram_idx] <= bus.write_value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_q        <= 5'h00;
            ie_q        <= 8'h00;
            dma_latch_q <= 8'hFF;
            wr_dma_q    <= 1'b0;
            cpu_reg_q   <= REG_NONE;
            dma_reg_q   <= REG_NONE;
            wram_q      <= 8'h00;
            hram_q      <= 8'h00;
            rd_primed_q <= 1'b0;
        end else begin
            // A request set on the same clock as a CPU clear wins.
            if_q <= ((cpu_we && cpu_reg == REG_IF) ? bus.write_value[4:0] : if_q) | irq_req;
            if (cpu_we && cpu_reg == REG_IE)  ie_q        <= bus.write_value;
            if (cpu_we && cpu_reg == REG_DMA) dma_latch_q <= bus.write_value;
            wr_dma_q    <= cpu_we && (cpu_reg == REG_DMA);
            cpu_reg_q   <= (dma_active && cpu_reg != REG_HRAM) ? REG_NONE : cpu_reg;
            dma_reg_q   <= dma_src_region(dma_src);
            wram_q      <= wram[wram_rd_idx];
            if (cpu_reg == REG_HRAM) hram_q <= hram[hram_idx];
            // Unmapped reads give 00 straight out of reset, FF afterwards.
            rd_primed_q <= 1'b1;
        end
    end

    assign mmio_reg_IF = {3'b111, if_q};
    assign mmio_reg_IE = ie_q;

    always_comb begin
        read_mux = {8{rd_primed_q}};
        case (cpu_reg_q)
            REG_ROM:  read_mux = rom_data;
            REG_WRAM: read_mux = wram_q;
            REG_HRAM: read_mux = hram_q;
            REG_IF:   read_mux = mmio_reg_IF;
            REG_IE:   read_mux = ie_q;
            REG_DMA:  read_mux = dma_latch_q;
            REG_EXT:  read_mux = ext_rdata;
            default:  read_mux = {8{rd_primed_q}};
        endcase
    end
    assign bus.read_out = read_mux;

    always_comb begin
        dma_rdata = 8'hFF;
        case (dma_reg_q)
            REG_ROM:  dma_rdata = rom_data;
            REG_WRAM: dma_rdata = wram_q;
            REG_EXT:  dma_rdata = ext_rdata;
            default:  dma_rdata = 8'hFF;
        endcase
    end

    // Outputs are forced idle while reset is held so ext_we drops at once.
    always_comb begin
        rom_addr  = 15'h0000;
        ext_addr  = 16'h0000;
        ext_wdata = 8'h00;
        ext_we    = 1'b0;
        if (!rst) begin
            if (dma_active) begin
                rom_addr  = dma_src[14:0];
                ext_addr  = dma_oam_phase ? dma_oam_addr : dma_src;
                ext_wdata = dma_oam_wdata;
                ext_we    = dma_oam_we;
            end else begin
                rom_addr  = bus.addr_select[14:0];
                ext_addr  = bus.addr_select;
                ext_wdata = bus.write_value;
                ext_we    = bus.write_enable && (cpu_reg == REG_EXT);
            end
        end
    end

    oam_dma_m #(
        .CLKS_PER_BYTE (DMA_CLKS_PER_BYTE),
        .LEN           (DMA_LEN)
    ) u_dma (
        .clk       (clk),
        .rst       (rst),
        .start     (dma_start),
        .src_page  (bus.write_value),
        .rdata     (dma_rdata),
        .active    (dma_active),
        .src_addr  (dma_src),
        .oam_phase (dma_oam_phase),
        .oam_we    (dma_oam_we),
        .oam_addr  (dma_oam_addr),
        .oam_wdata (dma_oam_wdata)
    );

endmodule

// File: tb/tb_mmu_m.sv
// tb/tb_mmu_m.sv - scoreboard bench for mmu_m
module tb_mmu_m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we;
    logic [7:0]  ext_rdata;
    logic [4:0]  irq_req;
    logic [7:0]  if_reg, ie_reg;
    logic        dma_active;

    always #5 clk = ~clk;

    mem_if bus();

    mmu_m #(.DMA_CLKS_PER_BYTE(4), .DMA_LEN(160)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_we      (ext_we),
        .ext_rdata   (ext_rdata),
        .irq_req     (irq_req),
        .mmio_reg_IF (if_reg),
        .mmio_reg_IE (ie_reg),
        .dma_active  (dma_active)
    );

    // ROM and external port models: data is a fixed function of address.
    always @(posedge clk) begin
        rom_data  <= rom_addr[7:0] ^ 8'hA5;
        ext_rdata <= ext_addr[7:0] ^ 8'h3C;
    end

    int          checks = 0;
    int          failures = 0;
    int          ext_cnt = 0;
    int          run = 0;
    int          last_run = 0;
    logic        rd_issue = 1'b0;
    logic [23:0] rd_q[$];
    logic [23:0] wr_q[$];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected reads one clock after issue, and one expected
    // OAM/external write per ext_we pulse.
    initial begin : monitor
        logic        st;
        logic [23:0] e;
        forever begin
            @(posedge clk);
            st = rd_issue;
            @(negedge clk);
            if (st && rd_q.size() != 0) begin
                e = rd_q.pop_front();
                chk($sformatf("read_%h", e[23:8]), {16'h0, bus.read_out}, {16'h0, e[7:0]});
            end
            if (ext_we === 1'b1) begin
                ext_cnt++;
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ext_unexpected: got write %h=%h expected none", ext_addr, ext_wdata);
                end else begin
                    e = wr_q.pop_front();
                    chk("ext_write", {ext_addr, ext_wdata}, e);
                end
            end
            if (dma_active === 1'b1) run++;
            else if (run != 0) begin
                last_run = run;
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int n);
        bus.addr_select  = a;
        bus.write_value  = d;
        bus.write_enable = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
        bus.addr_select = a;
        rd_issue = 1'b1;
        rd_q.push_back({a, exp});
        @(posedge clk);
        #1;
        rd_issue = 1'b0;
    endtask

    task automatic wait_dma_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (dma_active !== 1'b1) break;
        end
        chk("dma_done", {23'h0, dma_active}, 24'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_IF"}, {16'h0, if_reg}, 24'h0000E0);
        chk({tag, "_IE"}, {16'h0, ie_reg}, 24'h000000);
        chk({tag, "_dma_active"}, {23'h0, dma_active}, 24'h0);
        chk({tag, "_ext_we"}, {23'h0, ext_we}, 24'h0);
        chk({tag, "_read_out"}, {16'h0, bus.read_out}, 24'h0);
    endtask

    initial begin : stim
        int base;
        bus.addr_select  = 16'h0000;
        bus.write_value  = 8'h00;
        bus.write_enable = 1'b0;
        irq_req          = 5'h00;

        repeat (3) @(posedge clk);
        #3;
        chk_reset("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic decode
        cpu_read(16'hFF46, 8'hFF);
        cpu_write(16'hC123, 8'h5A, 3);
        cpu_read(16'hE123, 8'h5A);
        cpu_read(16'hC123, 8'h5A);
        cpu_read(16'hFEA5, 8'hFF);
        cpu_read(16'h1234, 8'h91);
        cpu_read(16'hFF44, 8'h78);
        wr_q.push_back({16'hFF40, 8'h91});
        cpu_write(16'hFF40, 8'h91, 1);
        cpu_write(16'h0100, 8'h55, 1);
        cpu_write(16'hFF80, 8'h3C, 2);
        cpu_read(16'hFF80, 8'h3C);

        // IE / IF
        cpu_write(16'hFFFF, 8'h01, 1);
        chk("IE_write", {16'h0, ie_reg}, 24'h000001);
        cpu_read(16'hFFFF, 8'h01);
        cpu_write(16'hFF0F, 8'h1F, 1);
        chk("IF_write", {16'h0, if_reg}, 24'h0000FF);
        bus.addr_select  = 16'hFF0F;
        bus.write_value  = 8'h00;
        bus.write_enable = 1'b1;
        irq_req          = 5'b00001;
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        irq_req          = 5'h00;
        chk("IF_race", {16'h0, if_reg}, 24'h0000E1);
        cpu_read(16'hFF0F, 8'hE1);

        // DMA from C000 with bus lock checks
        for (int i = 0; i < 160; i++) cpu_write(16'hC000 + 16'(i), 8'(i), 1);
        for (int i = 0; i < 160; i++) wr_q.push_back({16'hFE00 + 16'(i), 8'(i)});
        bus.addr_select  = 16'hFF46;
        bus.write_value  = 8'hC0;
        bus.write_enable = 1'b1;
        chk("dma_before_edge", {23'h0, dma_active}, 24'h0);
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        chk("dma_rise", {23'h0, dma_active}, 24'h1);
        cpu_read(16'hC000, 8'hFF);
        cpu_write(16'hFF90, 8'h77, 1);
        cpu_read(16'hFF90, 8'h77);
        cpu_write(16'hC000, 8'hEE, 1);
        wait_dma_idle();
        chk("dma_length", 24'(last_run), 24'd640);
        chk("dma_all_written", 24'(wr_q.size()), 24'd0);
        cpu_read(16'hC000, 8'h00);

        // DMA restart at byte 50
        for (int i = 0; i < 160; i++) cpu_write(16'hD000 + 16'(i), ~8'(i), 1);
        for (int i = 0; i < 50; i++)  wr_q.push_back({16'hFE00 + 16'(i), 8'(i)});
        for (int i = 0; i < 160; i++) wr_q.push_back({16'hFE00 + 16'(i), ~8'(i)});
        base = ext_cnt;
        cpu_write(16'hFF46, 8'hC0, 1);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (ext_cnt >= base + 50) break;
        end
        chk("restart_reach50", 24'(ext_cnt - base), 24'd50);
        @(posedge clk);
        #1;
        cpu_write(16'hFF46, 8'hD0, 1);
        wait_dma_idle();
        chk("restart_total", 24'(ext_cnt - base), 24'd210);
        chk("restart_all_written", 24'(wr_q.size()), 24'd0);
        cpu_read(16'hFF46, 8'hD0);

        // Reset mid-DMA, before the first OAM write
        cpu_write(16'hFF46, 8'hC0, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("mid_dma");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cpu_read(16'hFF46, 8'hFF);
        cpu_read(16'hC005, 8'h05);

        @(negedge clk);
        #1;
        chk("reads_drained", 24'(rd_q.size()), 24'd0);
        chk("writes_drained", 24'(wr_q.size()), 24'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
